psram_arbiter: RTL and testbench

// Shares the single PSRAM controller between NUM_REQ burst requesters (track players, recorder, UI).

---
 rtl/psram_arbiter_if.sv | 41 ++++
 rtl/psram_arbiter.sv | 142 ++++++++++++++
 tb/tb_psram_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_arbiter_if.sv
// Requester and PSRAM-controller signal bundle for psram_arbiter.
// slave is the arbiter's view; master is the view of the requesters and controller.
interface psram_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 23,
    parameter int LEN_W   = 10
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        done;
    logic [7:0]                rd_data;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [NUM_REQ*8-1:0]      wr_data;
    logic [NUM_REQ-1:0]        wr_ready;
    logic                      busy;
    logic                      mem_start_read;
    logic                      mem_start_write;
    logic                      mem_stop;
    logic [ADDR_W-1:0]         mem_addr;
    logic [7:0]                mem_dout;
    logic                      mem_r_valid;
    logic [7:0]                mem_din;
    logic                      mem_w_ready;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_data,
               mem_dout, mem_r_valid, mem_w_ready,
        output req_ready, done, rd_data, rd_valid, wr_ready, busy,
               mem_start_read, mem_start_write, mem_stop, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_data,
               mem_dout, mem_r_valid, mem_w_ready,
        input  req_ready, done, rd_data, rd_valid, wr_ready, busy,
               mem_start_read, mem_start_write, mem_stop, mem_addr, mem_din
    );
endinterface

// File: rtl/psram_arbiter.sv
// Round-robin burst arbiter sharing one PSRAM controller between NUM_REQ requesters.
// Steers read bytes and write-ready strobes to the granted requester and enforces CE# gap.
module psram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 23,
    parameter int LEN_W   = 10,
    parameter int GAP_CYC = 2
) (
    input  logic           clk,
    input  logic           rst,
    psram_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_XFER, S_STOP, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d, g_q, g_d, gsel, cand;
    logic               found;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic               wr_q, wr_d, zlen_q, zlen_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NUM_REQ-1:0] g_oh;
    logic               beat;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        zlen_d  = zlen_q;
        gap_d   = gap_q;

        bus.req_ready       = '0;
        bus.done            = '0;
        bus.rd_data         = '0;
        bus.rd_valid        = '0;
        bus.wr_ready        = '0;
        bus.mem_start_read  = 1'b0;
        bus.mem_start_write = 1'b0;
        bus.mem_stop        = 1'b0;
        bus.mem_addr        = '0;
        bus.mem_din         = '0;

        g_oh = NUM_REQ'(1) << g_q;
        beat = wr_q ? bus.mem_w_ready : bus.mem_r_valid;

        case (state_q)
            S_IDLE: begin
                if (found && !rst) begin
                    bus.req_ready = NUM_REQ'(1) << gsel;
                    g_d     = gsel;
                    addr_d  = bus.req_addr[gsel*ADDR_W +: ADDR_W];
                    len_d   = bus.req_len[gsel*LEN_W +: LEN_W];
                    wr_d    = bus.req_write[gsel];
                    rr_d    = (gsel == IDX_W'(NUM_REQ - 1)) ? '0 : gsel + IDX_W'(1);
                    cnt_d   = '0;
                    zlen_d  = (len_d == '0);
                    // A zero-length burst reuses STOP only to pulse done; mem_stop is suppressed there.
                    state_d = zlen_d ? S_STOP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.mem_addr        = addr_q;
                bus.mem_start_read  = !wr_q;
                bus.mem_start_write = wr_q;
                state_d             = S_XFER;
            end
            S_XFER: begin
                bus.mem_addr = addr_q;
                if (wr_q) begin
                    bus.mem_din  = bus.wr_data[g_q*8 +: 8];
                    bus.wr_ready = g_oh & {NUM_REQ{bus.mem_w_ready}};
                end else begin
                    bus.rd_data  = bus.mem_dout;
                    bus.rd_valid = g_oh & {NUM_REQ{bus.mem_r_valid}};
                end
                if (beat) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) state_d = S_STOP;
                end
            end
            S_STOP: begin
                bus.mem_addr = zlen_q ? '0 : addr_q;
                bus.mem_stop = !zlen_q;
                bus.done     = g_oh;
                gap_d        = '0;
                state_d      = (GAP_CYC == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = S_IDLE;
                else                              gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        bus.busy = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            zlen_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            zlen_q  <= zlen_d;
            gap_q   <= gap_d;
        end
    end
endmodule

// File: tb/tb_psram_arbiter.sv
// Directed scoreboard bench for psram_arbiter; the bench plays requesters and the controller.
module tb_psram_arbiter;
    localparam int NR = 4;
    localparam int AW = 23;
    localparam int LW = 10;
    localparam int GC = 2;

    logic clk;
    logic rst;

    psram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW)) bus ();

    psram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .GAP_CYC(GC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         grant_q[$];
    int         cyc       = 0;
    int         last_stop = -100;
    int         n_start   = 0;
    int         model_rr  = 0;
    int         done_cnt[NR];
    int         exp_done[NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.req_ready, bus.done, bus.rd_valid, bus.wr_ready, bus.rd_data, bus.busy,
                bus.mem_start_read, bus.mem_start_write, bus.mem_stop, bus.mem_addr, bus.mem_din};
    endfunction

    // Observe at the falling edge: scoreboard pops plus per-cycle protocol checks.
    task automatic sample();
        int nact;
        @(negedge clk);
        cyc++;
        if (|bus.rd_valid) begin
            if (exp_q.size() == 0) chk("rd_unexpected", bus.rd_valid, 0);
            else                   chk("rd_data", {bus.rd_valid, bus.rd_data},
                                       {bus.rd_valid & (bus.rd_valid - 1'b1) ^ bus.rd_valid, exp_q.pop_front()});
        end
        if (|bus.wr_ready) begin
            if (exp_q.size() == 0) chk("wr_unexpected", bus.wr_ready, 0);
            else                   chk("mem_din", bus.mem_din, exp_q.pop_front());
        end
        if (|bus.req_ready) begin
            if (grant_q.size() == 0) chk("grant_unexpected", bus.req_ready, 0);
            else                     chk("grant", bus.req_ready, 64'd1 << grant_q.pop_front());
        end
        for (int i = 0; i < NR; i++) if (bus.done[i]) done_cnt[i]++;
        nact = int'(bus.mem_start_read) + int'(bus.mem_start_write) + int'(bus.mem_stop);
        chk("cmd_mutex", nact <= 1, 1);
        if (bus.mem_start_read || bus.mem_start_write) begin
            n_start++;
            chk("start_gap", (cyc - last_stop) >= GC + 1, 1);
        end
        if (bus.mem_stop) last_stop = cyc;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_burst(input int r, input bit wr, input logic [AW-1:0] a, input int len,
                            input logic [7:0] base, input logic [7:0] step,
                            input bit junk, input bit keep);
        logic [7:0] d;
        bit         got;
        bus.req_write[r]         = wr;
        bus.req_addr[r*AW +: AW] = a;
        bus.req_len[r*LW +: LW]  = LW'(len);
        bus.req_valid[r]         = 1'b1;
        grant_q.push_back(r);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            sample();
            got = bus.req_ready[r];
            adv();
        end
        if (!got) begin
            chk("grant_timeout", 0, 1);
            grant_q.delete();
            bus.req_valid[r] = 1'b0;
            return;
        end
        model_rr = (r + 1) % NR;
        if (!keep) bus.req_valid[r] = 1'b0;
        if (len == 0) begin
            sample();
            chk("zlen_done", bus.done, 64'd1 << r);
            chk("zlen_nostop", bus.mem_stop, 0);
            adv();
        end else begin
            sample();
            chk(wr ? "start_write" : "start_read", {bus.mem_start_read, bus.mem_start_write},
                wr ? 2'b01 : 2'b10);
            chk("issue_addr", bus.mem_addr, a);
            adv();
            for (int i = 0; i < len; i++) begin
                if (i == 1) begin
                    sample();
                    adv();
                end
                d = base + 8'(i) * step;
                if (wr) begin
                    bus.wr_data[r*8 +: 8] = d;
                    bus.mem_w_ready       = 1'b1;
                end else begin
                    bus.mem_dout    = d;
                    bus.mem_r_valid = 1'b1;
                end
                exp_q.push_back(d);
                sample();
                if (i == len - 1) chk("xfer_addr", bus.mem_addr, a);
                adv();
                bus.mem_w_ready = 1'b0;
                bus.mem_r_valid = 1'b0;
            end
            chk("sb_drained", exp_q.size(), 0);
            if (junk) begin
                bus.mem_r_valid = 1'b1;
                bus.mem_dout    = 8'hEE;
            end
            sample();
            chk("stop", bus.mem_stop, 1);
            chk("done", bus.done, 64'd1 << r);
            chk("stop_addr", bus.mem_addr, a);
            adv();
        end
        exp_done[r]++;
        for (int g = 0; g < GC; g++) begin
            sample();
            chk("gap_busy", {bus.busy, bus.req_ready}, {1'b1, 4'b0});
            adv();
        end
        bus.mem_r_valid = 1'b0;
    endtask

    initial begin
        int n0;
        for (int i = 0; i < NR; i++) begin
            done_cnt[i] = 0;
            exp_done[i] = 0;
        end
        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_write   = '0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wr_data     = '0;
        bus.mem_dout    = '0;
        bus.mem_r_valid = 1'b0;
        bus.mem_w_ready = 1'b0;
        repeat (3) adv();
        rst = 1'b0;
        sample();
        chk("reset_outputs", all_outs(), 0);
        adv();

        // T1 read, T2 write
        do_burst(0, 1'b0, 23'h000100, 4, 8'h10, 8'h01, 1'b0, 1'b0);
        do_burst(1, 1'b1, 23'h000200, 3, 8'hAA, 8'h11, 1'b0, 1'b0);

        // T4 zero-length
        n0 = n_start;
        do_burst(2, 1'b0, 23'h000300, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("t4_no_start", n_start, n0);

        // T6 stray beats in STOP/GAP, then a clean burst
        do_burst(3, 1'b0, 23'h000400, 2, 8'h50, 8'h01, 1'b1, 1'b0);
        do_burst(0, 1'b0, 23'h000500, 3, 8'h60, 8'h01, 1'b0, 1'b0);

        // T3 all requesters valid continuously
        for (int r = 0; r < NR; r++) begin
            bus.req_write[r]         = 1'b0;
            bus.req_addr[r*AW +: AW] = AW'(r << 12);
            bus.req_len[r*LW +: LW]  = LW'(2);
        end
        bus.req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            int r;
            r = model_rr;
            do_burst(r, 1'b0, AW'(r << 12), 2, 8'(8'h80 + 16 * k), 8'h01, 1'b0, 1'b1);
        end
        bus.req_valid = '0;

        // T5 reset mid-XFER
        bus.req_write[0]       = 1'b0;
        bus.req_addr[0 +: AW]  = 23'h002000;
        bus.req_len[0 +: LW]   = LW'(8);
        bus.req_valid[0]       = 1'b1;
        grant_q.push_back(0);
        sample();
        chk("t5_ready", bus.req_ready[0], 1);
        adv();
        bus.req_valid[0] = 1'b0;
        sample();
        adv();
        for (int i = 0; i < 2; i++) begin
            bus.mem_dout    = 8'(8'hC0 + i);
            bus.mem_r_valid = 1'b1;
            exp_q.push_back(8'(8'hC0 + i));
            sample();
            adv();
        end
        bus.mem_r_valid = 1'b0;
        chk("t5_sb_drained", exp_q.size(), 0);
        rst = 1'b1;
        sample();
        adv();
        rst      = 1'b0;
        model_rr = 0;
        sample();
        chk("t5_reset_outputs", all_outs(), 0);
        adv();
        do_burst(1, 1'b0, 23'h003000, 2, 8'h30, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < NR; i++) chk("done_count", done_cnt[i], exp_done[i]);
        chk("grant_q_empty", grant_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
